main_mem_ctrl: RTL and testbench

- Sits directly downstream of the icache and the dcache miss/writeback paths in the load/store unit.
- Serialises block-granular requests from both caches, with icache priority, onto a single-ported main-memory array it owns.
- Each request is held for a fixed latency, then a one-cycle, latency-sensitive response pulse goes back to the requesting cache.

---
 rtl/main_mem_ctrl_if.sv | 34 +++
 rtl/main_mem_ctrl.sv | 115 +++++++++++
 tb/tb_main_mem_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_mem_ctrl_if.sv
// Cache-side bus of main_mem_ctrl: icache read channel and dcache read/write channel.
// A request transfers on a cycle where valid & ready are both high; responses are single-cycle pulses with no ready.
interface main_mem_ctrl_if #(
    parameter int BLOCK_WIDTH      = 64,
    parameter int BLOCK_ADDR_WIDTH = 29
);
    logic                        icache_req_valid;
    logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr;
    logic                        icache_req_ready;
    logic                        icache_resp_valid;
    logic [BLOCK_WIDTH-1:0]      icache_resp_block_data;

    logic                        dcache_req_valid;
    logic                        dcache_req_type;
    logic [BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr;
    logic [BLOCK_WIDTH-1:0]      dcache_req_block_data;
    logic                        dcache_req_ready;
    logic                        dcache_resp_valid;
    logic [BLOCK_WIDTH-1:0]      dcache_resp_block_data;

    modport master (
        output icache_req_valid, icache_req_block_addr,
        input  icache_req_ready, icache_resp_valid, icache_resp_block_data,
        output dcache_req_valid, dcache_req_type, dcache_req_block_addr, dcache_req_block_data,
        input  dcache_req_ready, dcache_resp_valid, dcache_resp_block_data
    );

    modport slave (
        input  icache_req_valid, icache_req_block_addr,
        output icache_req_ready, icache_resp_valid, icache_resp_block_data,
        input  dcache_req_valid, dcache_req_type, dcache_req_block_addr, dcache_req_block_data,
        output dcache_req_ready, dcache_resp_valid, dcache_resp_block_data
    );
endinterface

// File: rtl/main_mem_ctrl.sv
// Single-ported main memory shared by icache and dcache, icache-priority, fixed-latency pulse responses.
// Optional feature: define MAIN_MEM_CTRL_WRITE_ACK_EN to acknowledge dcache writes with a response pulse.
module main_mem_ctrl #(
    parameter int MEM_N_BLOCKS     = 1024,
    parameter int BLOCK_WIDTH      = 64,
    parameter int BLOCK_ADDR_WIDTH = 29,
    parameter int MEM_LATENCY      = 8
) (
    input  logic             clk,
    input  logic             rst,
    main_mem_ctrl_if.slave   bus,
    output logic [1:0]       dbg_state
);
    localparam int IDX_W = (MEM_N_BLOCKS > 1) ? $clog2(MEM_N_BLOCKS) : 1;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

`ifdef MAIN_MEM_CTRL_WRITE_ACK_EN
    localparam bit WRITE_ACK = 1'b1;
`else
    localparam bit WRITE_ACK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic {REQ_READ = 1'b0, REQ_WRITE = 1'b1} req_type_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   src_d, src_d_nxt;
    req_type_t              typ, typ_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [BLOCK_WIDTH-1:0] wdata, wdata_nxt;
    logic [BLOCK_WIDTH-1:0] rd_data;
    logic                   accept_i, accept_d;

    logic [BLOCK_WIDTH-1:0] mem [MEM_N_BLOCKS];

    assign dbg_state = state;
    assign rd_data   = mem[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            src_d <= 1'b0;
            typ   <= REQ_READ;
            idx   <= '0;
            wdata <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            src_d <= src_d_nxt;
            typ   <= typ_nxt;
            idx   <= idx_nxt;
            wdata <= wdata_nxt;
        end
    end

    // Commit happens on the edge that ends RESP; a reset on that edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && typ == REQ_WRITE) begin
            mem[idx] <= wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        src_d_nxt = src_d;
        typ_nxt   = typ;
        idx_nxt   = idx;
        wdata_nxt = wdata;

        bus.icache_req_ready = (state == IDLE);
        bus.dcache_req_ready = (state == IDLE) && !bus.icache_req_valid;
        accept_i = bus.icache_req_ready && bus.icache_req_valid;
        accept_d = bus.dcache_req_ready && bus.dcache_req_valid;

        case (state)
            IDLE: begin
                if (accept_i) begin
                    src_d_nxt = 1'b0;
                    typ_nxt   = REQ_READ;
                    idx_nxt   = bus.icache_req_block_addr[IDX_W-1:0];
                end else if (accept_d) begin
                    src_d_nxt = 1'b1;
                    typ_nxt   = req_type_t'(bus.dcache_req_type);
                    idx_nxt   = bus.dcache_req_block_addr[IDX_W-1:0];
                    wdata_nxt = bus.dcache_req_block_data;
                end
                if (accept_i || accept_d) begin
                    cnt_nxt   = CNT_INIT;
                    state_nxt = (MEM_LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                // Leaving on the count of one puts RESP exactly MEM_LATENCY cycles after acceptance.
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        bus.icache_resp_valid      = (state == RESP) && !src_d;
        bus.icache_resp_block_data = bus.icache_resp_valid ? rd_data : '0;
        bus.dcache_resp_valid      = (state == RESP) && src_d && (typ == REQ_READ || WRITE_ACK);
        bus.dcache_resp_block_data = '0;
        if (bus.dcache_resp_valid) begin
            bus.dcache_resp_block_data = (typ == REQ_WRITE) ? wdata : rd_data;
        end
    end
endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl: vector table plus hand sequences for arbitration, reset drop,
// back-to-back streaming and a MEM_LATENCY=1 instance.
module tb_main_mem_ctrl;
    localparam int BW = 64;
    localparam int AW = 29;
    localparam int NB = 1024;
    localparam int L  = 8;
`ifdef MAIN_MEM_CTRL_WRITE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [1:0] dbg0, dbg1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    main_mem_ctrl_if #(.BLOCK_WIDTH(BW), .BLOCK_ADDR_WIDTH(AW)) bus ();
    main_mem_ctrl_if #(.BLOCK_WIDTH(BW), .BLOCK_ADDR_WIDTH(AW)) bus1 ();

    main_mem_ctrl #(.MEM_N_BLOCKS(NB), .BLOCK_WIDTH(BW), .BLOCK_ADDR_WIDTH(AW), .MEM_LATENCY(L))
        dut (.clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg0));
    main_mem_ctrl #(.MEM_N_BLOCKS(NB), .BLOCK_WIDTH(BW), .BLOCK_ADDR_WIDTH(AW), .MEM_LATENCY(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1));

    typedef struct {
        logic          is_d;
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
        logic          exp_valid;
        logic [BW-1:0] exp_data;
    } vec_t;

    vec_t vecs[12];
    logic [BW-1:0] exp_q[$];
    int            exp_t_q[$];
    logic          sb_en = 1'b0;
    logic          prev_i = 1'b0, prev_d = 1'b0, prev1_i = 1'b0, prev1_d = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard for dcache responses during streamed sequences.
    always @(negedge clk) begin
        if (sb_en && bus.dcache_resp_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_resp", 1, 0);
            end else begin
                check("sb_data", bus.dcache_resp_block_data, exp_q.pop_front());
                check("sb_cycle", cyc, exp_t_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (bus.icache_resp_valid)  check("i_pulse_len", prev_i, 0);
        if (bus.dcache_resp_valid)  check("d_pulse_len", prev_d, 0);
        if (bus1.icache_resp_valid) check("l1_i_pulse_len", prev1_i, 0);
        if (bus1.dcache_resp_valid) check("l1_d_pulse_len", prev1_d, 0);
        prev_i  = bus.icache_resp_valid;
        prev_d  = bus.dcache_resp_valid;
        prev1_i = bus1.icache_resp_valid;
        prev1_d = bus1.dcache_resp_valid;
    end

    function automatic vec_t mk(input logic is_d, input logic wr, input logic [AW-1:0] addr,
                                input logic [BW-1:0] data, input logic ev, input logic [BW-1:0] ed);
        vec_t v;
        v.is_d = is_d; v.wr = wr; v.addr = addr; v.data = data; v.exp_valid = ev; v.exp_data = ed;
        return v;
    endfunction

    task automatic drive_idle();
        bus.icache_req_valid = 1'b0;
        bus.dcache_req_valid = 1'b0;
    endtask

    task automatic issue(input logic is_d, input logic wr, input logic [AW-1:0] addr,
                         input logic [BW-1:0] data, output int t_acc);
        @(posedge clk); #1;
        if (is_d) begin
            bus.dcache_req_valid      = 1'b1;
            bus.dcache_req_type       = wr;
            bus.dcache_req_block_addr = addr;
            bus.dcache_req_block_data = data;
        end else begin
            bus.icache_req_valid      = 1'b1;
            bus.icache_req_block_addr = addr;
        end
        t_acc = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (is_d ? bus.dcache_req_ready : bus.icache_req_ready) begin
                t_acc = cyc;
                break;
            end
        end
        check("accept_in_time", (t_acc >= 0), 1);
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int   t;
        logic early;
        logic sel_v, oth_v;
        logic [BW-1:0] sel_d;
        issue(v.is_d, v.wr, v.addr, v.data, t);
        early = 1'b0;
        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            sel_v = v.is_d ? bus.dcache_resp_valid : bus.icache_resp_valid;
            oth_v = v.is_d ? bus.icache_resp_valid : bus.dcache_resp_valid;
            sel_d = v.is_d ? bus.dcache_resp_block_data : bus.icache_resp_block_data;
            if (k < L) begin
                early = early | sel_v | oth_v | (|bus.icache_resp_block_data) | (|bus.dcache_resp_block_data);
            end else begin
                check($sformatf("vec%0d_resp_valid", n), sel_v, v.exp_valid);
                check($sformatf("vec%0d_resp_data", n), sel_d, v.exp_data);
                check($sformatf("vec%0d_other_valid", n), oth_v, 0);
                check($sformatf("vec%0d_ready_in_resp", n), bus.icache_req_ready, 0);
            end
        end
        check($sformatf("vec%0d_no_early_resp", n), early, 0);
        @(negedge clk);
        check($sformatf("vec%0d_ready_after", n), bus.icache_req_ready, 1);
    endtask

    task automatic reset_drop(input int offset, input logic [BW-1:0] new_data, input logic [BW-1:0] old_data);
        int   t;
        logic seen;
        vec_t rv;
        issue(1'b1, 1'b1, 29'h7, new_data, t);
        seen = 1'b0;
        for (int k = 1; k < offset; k++) begin
            @(negedge clk);
            seen = seen | bus.dcache_resp_valid | bus.icache_resp_valid;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check($sformatf("rst%0d_i_ready", offset), bus.icache_req_ready, 1);
        check($sformatf("rst%0d_d_ready", offset), bus.dcache_req_ready, 1);
        check($sformatf("rst%0d_state", offset), dbg0, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            seen = seen | bus.dcache_resp_valid | bus.icache_resp_valid;
        end
        check($sformatf("rst%0d_no_resp", offset), seen, 0);
        rv = mk(1'b1, 1'b0, 29'h7, '0, 1'b1, old_data);
        run_vec(rv, 100 + offset);
    endtask

    initial begin
        int t, ti, td, td_acc, n;
        int s_acc[5];
        logic [BW-1:0] idata, ddata;
        logic          s_wr[5];
        logic [AW-1:0] s_addr[5];
        logic [BW-1:0] s_data[5], s_exp[5];

        vecs[0]  = mk(1, 1, 29'h5,        64'hDEADBEEF_CAFEF00D, ACK, ACK ? 64'hDEADBEEF_CAFEF00D : 64'h0);
        vecs[1]  = mk(1, 0, 29'h5,        64'h0,                 1,   64'hDEADBEEF_CAFEF00D);
        vecs[2]  = mk(1, 0, 29'h405,      64'h0,                 1,   64'hDEADBEEF_CAFEF00D);
        vecs[3]  = mk(1, 1, 29'h10,       64'h11111111_11111111, ACK, ACK ? 64'h11111111_11111111 : 64'h0);
        vecs[4]  = mk(1, 1, 29'h20,       64'h22222222_22222222, ACK, ACK ? 64'h22222222_22222222 : 64'h0);
        vecs[5]  = mk(0, 0, 29'h10,       64'h0,                 1,   64'h11111111_11111111);
        vecs[6]  = mk(0, 0, 29'h405,      64'h0,                 1,   64'hDEADBEEF_CAFEF00D);
        vecs[7]  = mk(1, 1, 29'h3FF,      64'hA5A5A5A5_5A5A5A5A, ACK, ACK ? 64'hA5A5A5A5_5A5A5A5A : 64'h0);
        vecs[8]  = mk(1, 0, 29'h3FF,      64'h0,                 1,   64'hA5A5A5A5_5A5A5A5A);
        vecs[9]  = mk(0, 0, 29'h1FFFFFFF, 64'h0,                 1,   64'hA5A5A5A5_5A5A5A5A);
        vecs[10] = mk(1, 1, 29'h7,        64'h01234567_89ABCDEF, ACK, ACK ? 64'h01234567_89ABCDEF : 64'h0);
        vecs[11] = mk(1, 0, 29'h7,        64'h0,                 1,   64'h01234567_89ABCDEF);

        bus.icache_req_valid = 0; bus.icache_req_block_addr = '0;
        bus.dcache_req_valid = 0; bus.dcache_req_type = 0;
        bus.dcache_req_block_addr = '0; bus.dcache_req_block_data = '0;
        bus1.icache_req_valid = 0; bus1.icache_req_block_addr = '0;
        bus1.dcache_req_valid = 0; bus1.dcache_req_type = 0;
        bus1.dcache_req_block_addr = '0; bus1.dcache_req_block_data = '0;

        // Clock/reset.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_i_ready", bus.icache_req_ready, 1);
        check("rst_d_ready", bus.dcache_req_ready, 1);
        check("rst_i_valid", bus.icache_resp_valid, 0);
        check("rst_d_valid", bus.dcache_resp_valid, 0);
        check("rst_i_data", bus.icache_resp_block_data, 0);
        check("rst_d_data", bus.dcache_resp_block_data, 0);
        check("rst_state", dbg0, 0);
        check("rst_l1_d_ready", bus1.dcache_req_ready, 1);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Simultaneous requests: icache first, dcache stalls then follows.
        @(posedge clk); #1;
        bus.icache_req_valid = 1; bus.icache_req_block_addr = 29'h10;
        bus.dcache_req_valid = 1; bus.dcache_req_type = 0; bus.dcache_req_block_addr = 29'h20;
        @(negedge clk);
        check("arb_i_ready", bus.icache_req_ready, 1);
        check("arb_d_ready", bus.dcache_req_ready, 0);
        t = cyc;
        @(posedge clk); #1;
        bus.icache_req_valid = 0;
        ti = -1; td = -1; td_acc = -1; idata = '0; ddata = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.icache_resp_valid && ti < 0) begin ti = cyc; idata = bus.icache_resp_block_data; end
            if (bus.dcache_resp_valid && td < 0) begin td = cyc; ddata = bus.dcache_resp_block_data; end
            if (bus.dcache_req_valid && bus.dcache_req_ready && td_acc < 0) td_acc = cyc;
            @(posedge clk); #1;
            if (td_acc >= 0) bus.dcache_req_valid = 0;
        end
        check("arb_i_resp_lat", ti - t, 8);
        check("arb_i_resp_data", idata, 64'h11111111_11111111);
        check("arb_d_accept_lat", td_acc - t, 9);
        check("arb_d_resp_lat", td - t, 17);
        check("arb_d_resp_data", ddata, 64'h22222222_22222222);

        // Reset while a write is in flight: early in BUSY and during RESP.
        reset_drop(3, 64'hBAD0BAD0_BAD0BAD0, 64'h01234567_89ABCDEF);
        reset_drop(8, 64'hBAD1BAD1_BAD1BAD1, 64'h01234567_89ABCDEF);

        // Held-valid dcache stream: write then four reads, one acceptance per L+1 cycles.
        s_wr[0] = 1; s_addr[0] = 29'h30; s_data[0] = 64'h30303030_C0C0C0C0; s_exp[0] = 64'h30303030_C0C0C0C0;
        s_wr[1] = 0; s_addr[1] = 29'h30; s_data[1] = '0; s_exp[1] = 64'h30303030_C0C0C0C0;
        s_wr[2] = 0; s_addr[2] = 29'h5;  s_data[2] = '0; s_exp[2] = 64'hDEADBEEF_CAFEF00D;
        s_wr[3] = 0; s_addr[3] = 29'h10; s_data[3] = '0; s_exp[3] = 64'h11111111_11111111;
        s_wr[4] = 0; s_addr[4] = 29'h30; s_data[4] = '0; s_exp[4] = 64'h30303030_C0C0C0C0;
        sb_en = 1'b1;
        n = 0;
        @(posedge clk); #1;
        for (int g = 0; g < 100 && n < 5; g++) begin
            bus.dcache_req_valid = 1; bus.dcache_req_type = s_wr[n];
            bus.dcache_req_block_addr = s_addr[n]; bus.dcache_req_block_data = s_data[n];
            @(negedge clk);
            if (bus.dcache_req_ready) begin
                s_acc[n] = cyc;
                if (!s_wr[n] || ACK) begin
                    exp_q.push_back(s_exp[n]);
                    exp_t_q.push_back(cyc + L);
                end
                n++;
            end
            @(posedge clk); #1;
        end
        bus.dcache_req_valid = 0;
        check("stream_all_accepted", n, 5);
        for (int i = 1; i < 5; i++) check($sformatf("stream_gap%0d", i), s_acc[i] - s_acc[i-1], L + 1);
        repeat (12) @(negedge clk);
        check("stream_sb_drained", exp_q.size(), 0);
        sb_en = 1'b0;

        // MEM_LATENCY=1 instance with continuously held valid.
        @(posedge clk); #1;
        bus1.dcache_req_valid = 1; bus1.dcache_req_type = 1;
        bus1.dcache_req_block_addr = 29'h9; bus1.dcache_req_block_data = 64'h99998888_77776666;
        @(negedge clk);
        check("l1_wr_accept", bus1.dcache_req_ready, 1);
        @(posedge clk); #1;
        bus1.dcache_req_type = 0;
        @(negedge clk);
        check("l1_wr_d_ready_low", bus1.dcache_req_ready, 0);
        check("l1_wr_i_ready_low", bus1.icache_req_ready, 0);
        check("l1_wr_resp_valid", bus1.dcache_resp_valid, ACK);
        check("l1_wr_resp_data", bus1.dcache_resp_block_data, ACK ? 64'h99998888_77776666 : 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("l1_rd_accept", bus1.dcache_req_ready, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("l1_rd_ready_low", bus1.dcache_req_ready, 0);
        check("l1_rd_resp_valid", bus1.dcache_resp_valid, 1);
        check("l1_rd_resp_data", bus1.dcache_resp_block_data, 64'h99998888_77776666);
        @(posedge clk); #1;
        bus1.dcache_req_valid = 0;
        @(negedge clk);
        check("l1_ready_again", bus1.dcache_req_ready, 1);
        check("l1_resp_idle", bus1.dcache_resp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
